// File: rtl/csr_access_scheduler_pkg.sv
// Shared types for the CSR access scheduler: CSR operation codes, scheduler
// state encoding and the per-port request record.
package csr_access_scheduler_pkg;

  localparam int CSR_XLEN      = 32;
  localparam int CSR_ADR_W     = 12;
  localparam int CSR_REQ_PORTS = 2;

  typedef enum logic [1:0] {
    CSR_READ,
    CSR_WRITE,
    CSR_SET,
    CSR_CLEAR
  } csr_op_e;

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_ACCESS,
    CS_RESP
  } csr_sched_state_e;

  typedef struct packed {
    csr_op_e                op;
    logic                   rd_en;
    logic [CSR_ADR_W-1:0]   adr;
    logic [CSR_XLEN-1:0]    wdata;
  } csr_req_t;

endpackage

// File: rtl/csr_access_scheduler_arbiter.sv
// Fixed-priority two-port arbiter (port 1 wins) with a saturating loss counter
// that forces port 0 through after MAX_WAIT consecutive losses in IDLE.
module csr_req_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       idle,
  output logic       sel,
  output logic       any_req
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt_q;
  logic [CW-1:0] wait_cnt_d;

  assign any_req = |req;
  assign sel     = req[1] & ~(req[0] & (wait_cnt_q == WAIT_MAX));

  // The counter only moves on IDLE cycles, where the request is actually sampled.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (idle) begin
      if (req[0] & sel) begin
        wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
      end else begin
        wait_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/csr_access_scheduler.sv
// Shares the single CSR file port between the Zicsr pipeline (port 0) and the
// trap/debug unit (port 1): IDLE -> ACCESS (one-cycle strobe) -> RESP (Done).
module csr_access_scheduler
  import csr_access_scheduler_pkg::*;
#(
  parameter int XLEN           = CSR_XLEN,
  parameter int ADR_W          = CSR_ADR_W,
  parameter int MAX_WAIT       = 4,
  parameter bit REQ_HOLD_CHECK = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CSR_REQ_PORTS-1:0] Req,
  input  csr_op_e                  Op    [CSR_REQ_PORTS-1:0],
  input  logic [CSR_REQ_PORTS-1:0] RdEn,
  input  logic [ADR_W-1:0]         Adr   [CSR_REQ_PORTS-1:0],
  input  logic [XLEN-1:0]          WData [CSR_REQ_PORTS-1:0],
  output logic [CSR_REQ_PORTS-1:0] Gnt,
  output logic [CSR_REQ_PORTS-1:0] Done,
  output logic                     Err,
  output logic [XLEN-1:0]          RData,
  input  logic                     IllegalAccess,
  output logic                     CSREn,
  output csr_op_e                  CSROp,
  output logic                     CSRReadEn,
  output logic [ADR_W-1:0]         CSRAdr,
  output logic [XLEN-1:0]          WriteData,
  input  logic [XLEN-1:0]          ReadData,
  output csr_sched_state_e         dbg_state
);

  csr_sched_state_e state_q, state_d;
  logic             sel_q, sel_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             err_q, err_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic             arb_sel;
  logic             any_req;

  csr_req_arbiter #(.MAX_WAIT(MAX_WAIT)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (Req),
    .idle    (state_q == CS_IDLE),
    .sel     (arb_sel),
    .any_req (any_req)
  );

  // Port fields always follow sel so the CSR file never sees X outside ACCESS.
  assign CSRAdr    = Adr[sel_q];
  assign CSROp     = Op[sel_q];
  assign WriteData = WData[sel_q];
  assign CSREn     = (state_q == CS_ACCESS) & ~IllegalAccess;
  assign CSRReadEn = (state_q == CS_ACCESS) & RdEn[sel_q];

  assign Gnt       = gnt_q;
  assign Done      = done_q;
  assign Err       = err_q;
  assign RData     = rdata_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      CS_IDLE: begin
        if (any_req) begin
          sel_d   = arb_sel;
          gnt_d   = arb_sel ? 2'b10 : 2'b01;
          state_d = CS_ACCESS;
        end
      end
      CS_ACCESS: begin
        done_d  = gnt_q;
        err_d   = IllegalAccess;
        rdata_d = (RdEn[sel_q] && !IllegalAccess) ? ReadData : '0;
        state_d = CS_RESP;
      end
      CS_RESP: state_d = CS_IDLE;
      default: state_d = CS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CS_IDLE;
      sel_q   <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // The access completes regardless, but a requester dropping Req mid-access is a protocol bug.
  generate
    if (REQ_HOLD_CHECK) begin : g_req_hold
      a_req_held: assert property (@(posedge clk) disable iff (reset)
        (state_q == CS_ACCESS) |-> Req[sel_q]);
    end
  endgenerate

endmodule

// File: tb/tb_csr_access_scheduler.sv
// Directed bench for csr_access_scheduler with a small behavioural CSR file.
module tb_csr_access_scheduler;
  import csr_access_scheduler_pkg::*;

  // Handshake: a port raises Req with its fields in IDLE and holds it through
  // ACCESS; it may drop Req once Done is seen (in RESP).

  logic             clk;
  logic             rst;
  logic [1:0]       req;
  csr_op_e          op    [1:0];
  logic [1:0]       rden;
  logic [11:0]      adr   [1:0];
  logic [31:0]      wdata [1:0];
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             err;
  logic [31:0]      rdata;
  logic             illegal;
  logic             csr_en;
  csr_op_e          csr_op;
  logic             csr_read_en;
  logic [11:0]      csr_adr;
  logic [31:0]      csr_wdata;
  logic [31:0]      read_data;
  csr_sched_state_e dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  csr_access_scheduler #(.XLEN(32), .ADR_W(12), .MAX_WAIT(4), .REQ_HOLD_CHECK(1'b0)) dut (
    .clk           (clk),
    .reset         (rst),
    .Req           (req),
    .Op            (op),
    .RdEn          (rden),
    .Adr           (adr),
    .WData         (wdata),
    .Gnt           (gnt),
    .Done          (done),
    .Err           (err),
    .RData         (rdata),
    .IllegalAccess (illegal),
    .CSREn         (csr_en),
    .CSROp         (csr_op),
    .CSRReadEn     (csr_read_en),
    .CSRAdr        (csr_adr),
    .WriteData     (csr_wdata),
    .ReadData      (read_data),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // CSR file model: mscratch (0x340) read/write, mvendorid (0xF11) read-only.
  logic [31:0] mscratch;

  always_comb begin
    read_data = '0;
    illegal   = 1'b1;
    if (csr_adr == 12'h340) begin
      read_data = mscratch;
      illegal   = 1'b0;
    end else if (csr_adr == 12'hF11) begin
      read_data = 32'h1234_5678;
      illegal   = (csr_op != CSR_READ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mscratch <= '0;
    end else if (csr_en && csr_adr == 12'h340) begin
      case (csr_op)
        CSR_WRITE: mscratch <= csr_wdata;
        CSR_SET:   mscratch <= mscratch | csr_wdata;
        CSR_CLEAR: mscratch <= mscratch & ~csr_wdata;
        default:   mscratch <= mscratch;
      endcase
    end
  end

  typedef struct {
    logic [1:0]  req;
    csr_op_e     op0;
    csr_op_e     op1;
    logic [1:0]  rden;
    logic [11:0] adr0;
    logic [11:0] adr1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        exp_sel;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(logic [1:0] r, csr_op_e o0, csr_op_e o1, logic [1:0] re,
                              logic [11:0] a0, logic [11:0] a1, logic [31:0] w0,
                              logic [31:0] w1, logic s, logic e, logic [31:0] rd);
    vec_t v;
    v.req = r; v.op0 = o0; v.op1 = o1; v.rden = re; v.adr0 = a0; v.adr1 = a1;
    v.wd0 = w0; v.wd1 = w1; v.exp_sel = s; v.exp_err = e; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: one full IDLE -> ACCESS -> RESP transaction, applied at an IDLE negedge
  task automatic run_vec(input int idx, input vec_t v);
    req = v.req; op[0] = v.op0; op[1] = v.op1; rden = v.rden;
    adr[0] = v.adr0; adr[1] = v.adr1; wdata[0] = v.wd0; wdata[1] = v.wd1;
    @(negedge clk);
    check($sformatf("v%0d_gnt", idx), 32'(gnt), v.exp_sel ? 32'd2 : 32'd1);
    check($sformatf("v%0d_csren_access", idx), 32'(csr_en), 32'(!v.exp_err));
    @(negedge clk);
    check($sformatf("v%0d_done", idx), 32'(done), v.exp_sel ? 32'd2 : 32'd1);
    check($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
    check($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
    check($sformatf("v%0d_csren_resp", idx), 32'(csr_en), 32'd0);
    req = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int cyc;
    rst = 1'b1;
    req = 2'b00; rden = 2'b00;
    op[0] = CSR_READ; op[1] = CSR_READ;
    adr[0] = '0; adr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    repeat (2) @(negedge clk);

    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_csren", 32'(csr_en), 32'd0);
    check("rst_csrreaden", 32'(csr_read_en), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(CS_IDLE));
    rst = 1'b0;
    @(negedge clk);

    vecs[0]  = mk(2'b01, CSR_WRITE, CSR_READ,  2'b00, 12'h340, 12'h000, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 32'h0);
    vecs[1]  = mk(2'b10, CSR_READ,  CSR_READ,  2'b10, 12'h000, 12'h340, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    vecs[2]  = mk(2'b01, CSR_READ,  CSR_READ,  2'b01, 12'h340, 12'h000, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    vecs[3]  = mk(2'b10, CSR_READ,  CSR_WRITE, 2'b00, 12'h000, 12'hF11, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    vecs[4]  = mk(2'b10, CSR_READ,  CSR_READ,  2'b10, 12'h000, 12'hF11, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1234_5678);
    vecs[5]  = mk(2'b11, CSR_READ,  CSR_SET,   2'b11, 12'h340, 12'h340, 32'h0, 32'h0000_00F0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    vecs[6]  = mk(2'b01, CSR_CLEAR, CSR_READ,  2'b01, 12'h340, 12'h000, 32'hFFFF_0000, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEFF);
    vecs[7]  = mk(2'b01, CSR_READ,  CSR_READ,  2'b01, 12'h340, 12'h000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_BEFF);
    vecs[8]  = mk(2'b01, CSR_READ,  CSR_READ,  2'b00, 12'h340, 12'h000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    vecs[9]  = mk(2'b10, CSR_READ,  CSR_WRITE, 2'b10, 12'h000, 12'h7FF, 32'h0, 32'h5555_5555, 1'b1, 1'b1, 32'h0);
    vecs[10] = mk(2'b01, CSR_READ,  CSR_READ,  2'b01, 12'hF11, 12'h000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1234_5678);
    vecs[11] = mk(2'b10, CSR_READ,  CSR_READ,  2'b10, 12'h000, 12'h340, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_BEFF);
    vecs[12] = mk(2'b11, CSR_WRITE, CSR_READ,  2'b10, 12'h340, 12'h340, 32'h1111_1111, 32'h0, 1'b1, 1'b0, 32'h0000_BEFF);
    vecs[13] = mk(2'b01, CSR_READ,  CSR_READ,  2'b01, 12'h340, 12'h000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_BEFF);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Both ports requesting continuously: four port-1 grants, then one port-0 grant.
    op[0] = CSR_READ; op[1] = CSR_READ; rden = 2'b11; adr[0] = 12'h340; adr[1] = 12'h340;
    req = 2'b11;
    n = 0;
    cyc = 0;
    while (n < 10 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (gnt != 2'b00) begin
        check($sformatf("starve_gnt%0d", n), 32'(gnt), (n % 5 == 4) ? 32'd1 : 32'd2);
        n++;
      end
    end
    check("starve_grant_count", n, 10);
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);

    // Reset during ACCESS: strobe drops at once and the partial write never lands.
    op[0] = CSR_WRITE; adr[0] = 12'h340; wdata[0] = 32'hCAFE_F00D; rden = 2'b00;
    req = 2'b01;
    @(negedge clk);
    check("rsta_gnt_before", 32'(gnt), 32'd1);
    check("rsta_csren_before", 32'(csr_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rsta_csren_after", 32'(csr_en), 32'd0);
    check("rsta_gnt_after", 32'(gnt), 32'd0);
    check("rsta_state_after", 32'(dbg_state), 32'(CS_IDLE));
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rsta_no_done%0d", k), 32'(done), 32'd0);
    end
    run_vec(100, mk(2'b10, CSR_READ, CSR_READ, 2'b10, 12'h000, 12'h340, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0));

    // Req[0] dropped in ACCESS while port 1 raises its request.
    op[0] = CSR_READ; adr[0] = 12'hF11; op[1] = CSR_READ; adr[1] = 12'h340; rden = 2'b11;
    req = 2'b01;
    @(negedge clk);
    check("drop_gnt0", 32'(gnt), 32'd1);
    req = 2'b10;
    @(negedge clk);
    check("drop_done0", 32'(done), 32'd1);
    check("drop_rdata0", rdata, 32'h1234_5678);
    check("drop_err0", 32'(err), 32'd0);
    @(negedge clk);
    check("drop_idle_state", 32'(dbg_state), 32'(CS_IDLE));
    check("drop_idle_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    check("drop_gnt1", 32'(gnt), 32'd2);
    @(negedge clk);
    check("drop_done1", 32'(done), 32'd2);
    check("drop_rdata1", rdata, 32'h0);
    req = 2'b00;
    @(negedge clk);
    check("final_state", 32'(dbg_state), 32'(CS_IDLE));

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
